out_channel_reader: RTL

- Consumer end of the program out channel.
- The executor's out instruction pushes one MemoryElementWidth word per step into a ring of NOut words; this block buffers them and drains them, in order, on a valid/ready stream to the test host or UART bridge.
- It also reports occupancy, overflow and drain completion, so the harness can raise success only after every output word has been consumed.

---
 rtl/out_channel_pkg.sv | 20 ++
 rtl/out_channel_reader_if.sv | 40 ++++
 rtl/out_channel_ram.sv | 36 +++
 rtl/out_channel_reader.sv | 115 +++++++++++
 4 files changed

// File: rtl/out_channel_pkg.sv
// Shared definitions for the program out channel.
// Contents:
//   MemoryElementWidthDefault - default out-channel word width
//   NOutDefault               - default ring capacity in words
//   word_t                    - one out-channel word
//   ptr_inc                   - modulo-n pointer increment, also used by the executor's outMemPos
package out_channel_pkg;

  localparam int unsigned MemoryElementWidthDefault = 12;
  localparam int unsigned NOutDefault = 2000;

  typedef logic [MemoryElementWidthDefault-1:0] word_t;

  // Callers cast the 32-bit result down to their own pointer width.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                          input int unsigned n = NOutDefault);
    return (ptr == 32'(n - 1)) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/out_channel_reader_if.sv
// Bundle between the out-channel reader and its surroundings (executor push side,
// host/UART drain side and harness status).
// Signals:
//   push_valid, push_data   - executor out instruction write
//   program_finished        - executor finished (level)
//   rd_valid, rd_ready      - drain handshake
//   rd_data                 - head-of-stream word
//   count                   - words held in the ring (output register excluded)
//   overflow                - sticky overwrite flag
//   drained                 - finished, nothing left to deliver
// Modports: slave is the reader block, master is the environment driving it.
interface out_channel_reader_if
  import out_channel_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = MemoryElementWidthDefault,
  parameter int unsigned NOut = NOutDefault
);
  localparam int unsigned PtrWidth = $clog2(NOut);

  logic                          push_valid;
  logic [MemoryElementWidth-1:0] push_data;
  logic                          program_finished;
  logic                          rd_valid;
  logic                          rd_ready;
  logic [MemoryElementWidth-1:0] rd_data;
  logic [PtrWidth:0]             count;
  logic                          overflow;
  logic                          drained;

  modport slave (
    input  push_valid, push_data, program_finished, rd_ready,
    output rd_valid, rd_data, count, overflow, drained
  );

  modport master (
    output push_valid, push_data, program_finished, rd_ready,
    input  rd_valid, rd_data, count, overflow, drained
  );

endinterface

// File: rtl/out_channel_ram.sv
// Simple dual-port ring storage: synchronous write, synchronous read.
// Ports:
//   i_clk    - clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address, sampled every cycle
//   o_rdata  - registered read data
// A same-cycle write to the read address returns the new data, so the reader can
// prefetch the head word without a separate hazard path.
module out_channel_ram #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 2000,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [AddrWidth-1:0] i_waddr,
  input  logic [Width-1:0]     i_wdata,
  input  logic [AddrWidth-1:0] i_raddr,
  output logic [Width-1:0]     o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/out_channel_reader.sv
// Consumer end of the program out channel. Buffers executor out-instruction words in a
// ring of NOut words and drains them in order on a valid/ready stream.
// Ports:
//   clock  - single clock, posedge
//   reset  - asynchronous, active-high
//   bus    - out_channel_reader_if.slave (push, drain handshake and status)
// The executor never stalls: a push into a full ring with no drain that cycle overwrites
// the oldest word and sets the sticky overflow flag.
module out_channel_reader
  import out_channel_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = MemoryElementWidthDefault,
  parameter int unsigned NOut = NOutDefault
) (
  input logic                 clock,
  input logic                 reset,
  out_channel_reader_if.slave bus
);

  localparam int unsigned PtrWidth = $clog2(NOut);
  localparam logic [PtrWidth:0] CountOne = (PtrWidth + 1)'(1);
  localparam logic [PtrWidth:0] CountFull = (PtrWidth + 1)'(NOut);

  logic [PtrWidth-1:0]           r_wr_ptr;
  logic [PtrWidth-1:0]           r_rd_ptr;
  logic [PtrWidth:0]             r_count;
  logic                          r_rd_valid;
  logic [MemoryElementWidth-1:0] r_rd_data;
  logic                          r_overflow;
  logic                          r_drained;

  logic [PtrWidth-1:0]           w_wr_ptr_d;
  logic [PtrWidth-1:0]           w_rd_ptr_d;
  logic [PtrWidth:0]             w_count_d;
  logic                          w_push;
  logic                          w_load;
  logic                          w_full_push;
  logic                          w_ring_empty;
  logic [MemoryElementWidth-1:0] w_ram_q;
  logic [MemoryElementWidth-1:0] w_load_data;

  always_comb begin
    w_push       = bus.push_valid;
    w_ring_empty = (r_count == '0);
    // With an empty ring a push goes straight to the output register (bypass).
    w_load       = (!r_rd_valid || bus.rd_ready) && (!w_ring_empty || w_push);
    w_full_push  = w_push && (r_count == CountFull) && !w_load;
    w_load_data  = w_ring_empty ? bus.push_data : w_ram_q;

    w_wr_ptr_d = r_wr_ptr;
    if (w_push) begin
      w_wr_ptr_d = PtrWidth'(ptr_inc(32'(r_wr_ptr), NOut));
    end

    // A full push drops the oldest word, so the read side moves along with the writer.
    w_rd_ptr_d = r_rd_ptr;
    if (w_load || w_full_push) begin
      w_rd_ptr_d = PtrWidth'(ptr_inc(32'(r_rd_ptr), NOut));
    end

    w_count_d = r_count;
    if (w_push && !w_load && !w_full_push) begin
      w_count_d = r_count + CountOne;
    end else if (!w_push && w_load) begin
      w_count_d = r_count - CountOne;
    end
  end

  // The RAM reads the next head address, so its output is the head word next cycle.
  out_channel_ram #(
    .Width     (MemoryElementWidth),
    .Depth     (NOut),
    .AddrWidth (PtrWidth)
  ) u_ram (
    .i_clk   (clock),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.push_data),
    .i_raddr (w_rd_ptr_d),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
      r_drained  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
      if (w_load) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_load_data;
      end else if (bus.rd_ready) begin
        r_rd_valid <= 1'b0;
      end
      if (w_full_push) begin
        r_overflow <= 1'b1;
      end
      r_drained <= bus.program_finished && w_ring_empty && !r_rd_valid && !w_push;
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.drained  = r_drained;

endmodule
